// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared constants and the read-owner encoding for the memory port arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_port_arbiter_pkg;

  localparam int REG_WIDTH           = 32;
  localparam int INST_MEM_ADDR_WIDTH = 10;

  // Which requester the read currently in flight belongs to
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_LS   = 2'd2
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/mem_port_starve_ctr.sv
// ---------------------------------------------------------------------------
// mem_port_starve_ctr
// Saturating up-counter with synchronous clear; clear has priority over inc.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_starve_ctr #(
  parameter int WIDTH = 4,
  parameter int MAX   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_at_max
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX);

  logic [WIDTH-1:0] r_cnt;

  // Count up on inc, stick at MAX, clear on request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_at_max = (r_cnt == C_MAX);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between fetch (IF) and load/store (LS).
// LS has priority; IF is forced through after STARVE_MAX consecutive losses.
// Optional build macro: MEM_PORT_ARBITER_PERF_EN adds conflict/starve counters.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int REG_WIDTH  = mem_port_arbiter_pkg::REG_WIDTH,
  parameter int ADDR_WIDTH = mem_port_arbiter_pkg::INST_MEM_ADDR_WIDTH,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_if_req,
  input  logic [REG_WIDTH-1:0]  i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [REG_WIDTH-1:0]  o_if_rdata,
  input  logic                  i_ls_req,
  input  logic                  i_ls_we,
  input  logic [REG_WIDTH-1:0]  i_ls_addr,
  input  logic [REG_WIDTH-1:0]  i_ls_wdata,
  output logic                  o_ls_gnt,
  output logic                  o_ls_rvalid,
  output logic [REG_WIDTH-1:0]  o_ls_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [REG_WIDTH-1:0]  o_mem_wdata,
  input  logic [REG_WIDTH-1:0]  i_mem_rdata
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,
  output logic [15:0]           o_conflict_cnt,
  output logic [15:0]           o_starve_hit
`endif
);

  import mem_port_arbiter_pkg::*;

  logic                 w_at_max;
  logic [3:0]           w_starve_cnt;
  logic                 w_if_gnt;
  logic                 w_ls_gnt;
  logic                 w_ls_rd;
  logic                 w_starve_inc;
  logic                 w_starve_clr;
  owner_e               r_owner;
  logic [REG_WIDTH-1:0] r_if_hold;
  logic [REG_WIDTH-1:0] r_ls_hold;

  // Grants are forced low while reset is asserted
  assign w_if_gnt = rst_n & i_if_req & (~i_ls_req | w_at_max);
  assign w_ls_gnt = rst_n & i_ls_req & ~w_if_gnt;
  assign w_ls_rd  = w_ls_gnt & ~i_ls_we;

  assign w_starve_inc = i_if_req & w_ls_gnt;
  assign w_starve_clr = w_if_gnt | ~i_if_req;

  mem_port_starve_ctr #(
    .WIDTH (4),
    .MAX   (STARVE_MAX)
  ) u_starve_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (w_starve_inc),
    .i_clr    (w_starve_clr),
    .o_cnt    (w_starve_cnt),
    .o_at_max (w_at_max)
  );

  assign o_if_gnt = w_if_gnt;
  assign o_ls_gnt = w_ls_gnt;

  // Steer the granted requester onto the memory port; idle drives zeros
  always_comb begin
    o_mem_en    = w_if_gnt | w_ls_gnt;
    o_mem_we    = w_ls_gnt & i_ls_we;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_if_gnt) begin
      o_mem_addr = i_if_addr[ADDR_WIDTH+1:2];
    end else if (w_ls_gnt) begin
      o_mem_addr  = i_ls_addr[ADDR_WIDTH+1:2];
      o_mem_wdata = i_ls_wdata;
    end
  end

  // Record who owns this cycle's read and latch returning data for hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner   <= OWNER_NONE;
      r_if_hold <= '0;
      r_ls_hold <= '0;
    end else begin
      if (r_owner == OWNER_IF) r_if_hold <= i_mem_rdata;
      if (r_owner == OWNER_LS) r_ls_hold <= i_mem_rdata;
      if (w_if_gnt)     r_owner <= OWNER_IF;
      else if (w_ls_rd) r_owner <= OWNER_LS;
      else              r_owner <= OWNER_NONE;
    end
  end

  // Returned word passes straight through in the response cycle
  assign o_if_rvalid = (r_owner == OWNER_IF);
  assign o_ls_rvalid = (r_owner == OWNER_LS);
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : r_if_hold;
  assign o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : r_ls_hold;

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic w_conf_max_unused;
  logic w_hit_max_unused;

  mem_port_starve_ctr #(
    .WIDTH (16),
    .MAX   (16'hFFFF)
  ) u_conflict_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (i_if_req & i_ls_req),
    .i_clr    (1'b0),
    .o_cnt    (o_conflict_cnt),
    .o_at_max (w_conf_max_unused)
  );

  mem_port_starve_ctr #(
    .WIDTH (16),
    .MAX   (16'hFFFF)
  ) u_starve_hit_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (w_if_gnt & i_ls_req),
    .i_clr    (1'b0),
    .o_cnt    (o_starve_hit),
    .o_at_max (w_hit_max_unused)
  );
`endif

  // Address bits outside the word index are intentionally dropped
  logic w_unused;
  assign w_unused = ^{i_if_addr, i_ls_addr, w_starve_cnt};

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the fetch unit (IF) and the load/store unit (LS).
- Issues at most one memory access per cycle and tracks which requester owns the 1-cycle-latency read.
- Steers the returned word back to that requester.
- Sits between the core pipeline and the memory array. It replaces the current arrangement, where fetch and data read the array on separate addresses.

Parameters:
- REG_WIDTH, 32, data and address width of both requesters.
- ADDR_WIDTH, 10, word-index width of the memory (depth = 2**ADDR_WIDTH).
- STARVE_MAX, 4, number of consecutive cycles IF may lose to LS before IF is forced to win (range 1..15).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request, held until granted.
- if_addr  in  REG_WIDTH  fetch byte address (pc).
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  fetch data valid (registered).
- if_rdata  out  REG_WIDTH  fetched instruction.
- ls_req  in  1  load/store request, held until granted.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  REG_WIDTH  data byte address.
- ls_wdata  in  REG_WIDTH  store data.
- ls_gnt  out  1  LS accepted this cycle (combinational).
- ls_rvalid  out  1  load data valid (registered).
- ls_rdata  out  REG_WIDTH  loaded word.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  word index = selected byte address [ADDR_WIDTH+1:2].
- mem_wdata  out  REG_WIDTH  write data.
- mem_rdata  in  REG_WIDTH  memory read data, valid one cycle after a read strobe.

Behaviour:
- Reset (rst_n low, async): if_rvalid = 0, ls_rvalid = 0, owner = NONE, starve_cnt = 0. All rdata outputs are 0. Combinational outputs are 0 while in reset.
- Owner register states: NONE, IF, LS.
  - Updated every cycle to the requester granted a read this cycle.
  - A store grant or no grant sets it to NONE.
- Arbitration (combinational, per cycle):
  - Only one request: that requester is granted.
  - Both requesting: LS wins, unless starve_cnt == STARVE_MAX, in which case IF wins.
  - At most one of if_gnt/ls_gnt is high.
- Starvation counter:
  - Increments when if_req=1 and ls_gnt=1.
  - Clears when if_gnt=1 or if_req=0.
  - Saturates at STARVE_MAX.
- Memory drive:
  - mem_en = if_gnt | ls_gnt.
  - mem_we = ls_gnt & ls_we.
  - mem_addr and mem_wdata are taken from the granted requester.
  - When idle, mem_addr is 0 and mem_we is 0.
- Read latency is exactly 1 cycle:
  - Grant in cycle N: x_rvalid=1 in cycle N+1 and x_rdata = mem_rdata.
  - rdata holds its last value when rvalid=0.
- Stores produce ls_gnt only; no ls_rvalid.
- Back-to-back operation:
  - A new grant may issue in the same cycle a previous read returns (full throughput).
  - A store to address A granted in cycle N, followed by a read of A in N+1, returns the new data.
- Address bits [1:0] are ignored (word-aligned access only). Address bits above ADDR_WIDTH+1 are ignored (wrap-around).
- Requesters must hold req/addr/wdata stable until granted. Dropping req before grant is permitted and cancels the request.
- Reset asserted mid-read discards the pending rvalid. No response follows reset release.

Optional Feature:
- MEM_PORT_ARBITER_PERF_EN defined:
  - Adds output conflict_cnt [15:0].
  - Counts cycles with if_req & ls_req both high; saturates at 16'hFFFF; cleared by reset.
  - Adds output starve_hit [15:0], counting forced IF wins; saturating.
- Not defined: both ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines file:
  - Owner encoding (NONE=2'd0, IF=2'd1, LS=2'd2).
  - REG_WIDTH and INST_MEM_ADDR_WIDTH constants, reused as parameter defaults.
- One natural sub-module: mem_port_starve_ctr.
  - Saturating starvation counter with inc/clr inputs and an at_max output.
  - Also instantiated for the perf counters with width 16.

Test Plan:
- Only if_req, if_addr=0x0000_0010, memory word 4 = 0xDEADBEEF -> if_gnt=1 in cycle 0; if_rvalid=1 with if_rdata=0xDEADBEEF in cycle 1; ls_rvalid stays 0.
- Same-cycle if_req and ls_req load, ls_addr=0x8 -> ls_gnt=1, if_gnt=0, mem_addr=2; next cycle ls_rvalid=1, if_rvalid=0.
- ls_req held high with if_req for 6 cycles, STARVE_MAX=4 -> LS granted cycles 0-3, IF granted cycle 4 (starve_cnt=4), LS granted cycle 5.
- Store ls_addr=0x20, wdata=0x12345678 in cycle 0, then load 0x20 in cycle 1 -> mem_we=1 in cycle 0 with no ls_rvalid in cycle 1; ls_rdata=0x12345678 with ls_rvalid=1 in cycle 2.
- Load granted in cycle 0, rst_n pulsed low in cycle 1 -> ls_rvalid=0, owner=NONE, starve_cnt=0; no rvalid after release.
- With MEM_PORT_ARBITER_PERF_EN, 3 conflict cycles with one forced IF win (STARVE_MAX=2) -> conflict_cnt=3, starve_hit=1.
